cv32e40p_rf_wb_arbiter: RTL

// Write-back stage directly upstream of cv32e40p_register_file; drives its two write ports.

---
 rtl/cv32e40p_pkg.sv | 21 ++
 rtl/cv32e40p_rf_wb_fifo.sv | 67 ++++++
 rtl/cv32e40p_rf_wb_arbiter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/cv32e40p_pkg.sv
// Shared types for the register-file write-back arbiter: buffered LSU return entry
// and default FIFO depth.
package cv32e40p_pkg;

  localparam int RF_WB_DEPTH_DEFAULT = 2;
  localparam int RF_WB_AW_MAX        = 6;
  localparam int RF_WB_DW_MAX        = 32;

  typedef struct packed {
    logic [RF_WB_AW_MAX-1:0] waddr;
    logic [RF_WB_DW_MAX-1:0] wdata;
    logic [RF_WB_DW_MAX-1:0] wdata_hi;
    logic                    pair;
  } rf_wb_entry_t;

  // A 64-bit pair may only target an even base register.
  function automatic logic rf_wb_pair_ok(input rf_wb_entry_t e);
    return e.pair & ~e.waddr[0];
  endfunction

endpackage

// File: rtl/cv32e40p_rf_wb_fifo.sv
// Synchronous FIFO of buffered LSU returns; pointers wrap modulo DEPTH and a
// push is accepted when full only if the head pops in the same cycle.
module cv32e40p_rf_wb_fifo
  import cv32e40p_pkg::*;
#(
  parameter int DEPTH = RF_WB_DEPTH_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  rf_wb_entry_t push_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output rf_wb_entry_t head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  rf_wb_entry_t     mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s;
  logic             do_pop_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  assign full      = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == '0);
  assign head      = mem_r[rd_ptr_r];
  assign do_pop_s  = pop & ~empty;
  assign do_push_s = push & (~full | do_pop_s);

  // Pointer, occupancy and storage update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= ptr_inc(wr_ptr_r);
      end
      if (do_pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/cv32e40p_rf_wb_arbiter.sv
// Write-back arbiter feeding the two register-file write ports, with a buffered
// LSU return FIFO and a pending-load scoreboard for RAW/WAW hazard detection.
module cv32e40p_rf_wb_arbiter
  import cv32e40p_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = RF_WB_DEPTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_we_i,
  input  logic [ADDR_WIDTH-1:0] ex_waddr_i,
  input  logic [DATA_WIDTH-1:0] ex_wdata_i,
  output logic                  ex_stall_o,
  input  logic                  apu_we_i,
  input  logic [ADDR_WIDTH-1:0] apu_waddr_i,
  input  logic [DATA_WIDTH-1:0] apu_wdata_i,
  input  logic                  lsu_valid_i,
  output logic                  lsu_ready_o,
  input  logic                  lsu_pair_i,
  input  logic [ADDR_WIDTH-1:0] lsu_waddr_i,
  input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
  input  logic [DATA_WIDTH-1:0] lsu_wdata_hi_i,
  input  logic                  pend_set_i,
  input  logic                  pend_pair_i,
  input  logic [ADDR_WIDTH-1:0] pend_addr_i,
  input  logic [ADDR_WIDTH-1:0] raddr_a_i,
  input  logic [ADDR_WIDTH-1:0] raddr_b_i,
  input  logic [ADDR_WIDTH-1:0] raddr_c_i,
  output logic                  hazard_a_o,
  output logic                  hazard_b_o,
  output logic                  hazard_c_o,
  output logic                  we_a_o,
  output logic [ADDR_WIDTH-1:0] waddr_a_o,
  output logic [DATA_WIDTH-1:0] wdata_a_o,
  output logic                  we_b_o,
  output logic [ADDR_WIDTH-1:0] waddr_b_o,
  output logic [DATA_WIDTH-1:0] wdata_b_o,
  output logic [DATA_WIDTH-1:0] wdata_b1_o,
  output logic                  instr64_oe_o
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  rf_wb_entry_t          push_entry_s;
  rf_wb_entry_t          fifo_head_s;
  logic                  fifo_full_s;
  logic                  fifo_empty_s;
  logic                  fifo_push_s;
  logic                  fifo_pop_s;
  logic                  fifo_wr_s;
  logic                  unused_head_s;
  logic [ADDR_WIDTH-1:0] head_waddr_s;

  logic [NUM_REGS-1:0]   pend_q;
  logic [NUM_REGS-1:0]   pend_next_s;
  logic [NUM_REGS-1:0]   set_mask_s;
  logic [NUM_REGS-1:0]   clr_mask_s;
  logic                  drain_q;
  logic [ADDR_WIDTH-1:0] drain_addr_q;
  logic                  drain_pair_q;

  assign push_entry_s.waddr    = RF_WB_AW_MAX'(lsu_waddr_i);
  assign push_entry_s.wdata    = RF_WB_DW_MAX'(lsu_wdata_i);
  assign push_entry_s.wdata_hi = RF_WB_DW_MAX'(lsu_wdata_hi_i);
  assign push_entry_s.pair     = lsu_pair_i;

  assign head_waddr_s  = fifo_head_s.waddr[ADDR_WIDTH-1:0];
  assign unused_head_s = ^fifo_head_s;

  // APU owns port B whenever it writes; the FIFO head only pops on idle cycles.
  assign fifo_pop_s  = ~apu_we_i & ~fifo_empty_s;
  assign fifo_wr_s   = fifo_pop_s & (head_waddr_s != '0);
  assign lsu_ready_o = ~fifo_full_s | fifo_pop_s;
  assign fifo_push_s = lsu_valid_i & lsu_ready_o;

  cv32e40p_rf_wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push_s),
    .push_data (push_entry_s),
    .pop       (fifo_pop_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .head      (fifo_head_s)
  );

  assign ex_stall_o = ex_we_i & pend_q[ex_waddr_i];
  assign we_a_o     = rst_n & ex_we_i & ~ex_stall_o;
  assign waddr_a_o  = ex_waddr_i;
  assign wdata_a_o  = ex_wdata_i;

  // Port B mux: APU first, then FIFO head (x0 destinations are dropped).
  always_comb begin
    we_b_o       = 1'b0;
    waddr_b_o    = '0;
    wdata_b_o    = '0;
    wdata_b1_o   = '0;
    instr64_oe_o = 1'b0;
    if (apu_we_i) begin
      we_b_o    = rst_n;
      waddr_b_o = apu_waddr_i;
      wdata_b_o = apu_wdata_i;
    end else if (fifo_pop_s) begin
      we_b_o       = fifo_wr_s;
      waddr_b_o    = head_waddr_s;
      wdata_b_o    = fifo_head_s.wdata[DATA_WIDTH-1:0];
      wdata_b1_o   = fifo_head_s.wdata_hi[DATA_WIDTH-1:0];
      instr64_oe_o = fifo_wr_s & rf_wb_pair_ok(fifo_head_s);
    end else begin
      we_b_o = 1'b0;
    end
  end

  assign hazard_a_o = pend_q[raddr_a_i];
  assign hazard_b_o = pend_q[raddr_b_i];
  assign hazard_c_o = pend_q[raddr_c_i];

  // Scoreboard next state: set wins over the delayed clear; bit 0 stays clear.
  always_comb begin
    set_mask_s = '0;
    clr_mask_s = '0;
    if (pend_set_i) begin
      set_mask_s[pend_addr_i] = 1'b1;
      if (pend_pair_i) begin
        set_mask_s[pend_addr_i + ADDR_WIDTH'(1)] = 1'b1;
      end else begin
        set_mask_s = set_mask_s;
      end
    end else begin
      set_mask_s = '0;
    end
    if (drain_q) begin
      clr_mask_s[drain_addr_q] = 1'b1;
      if (drain_pair_q) begin
        clr_mask_s[drain_addr_q + ADDR_WIDTH'(1)] = 1'b1;
      end else begin
        clr_mask_s = clr_mask_s;
      end
    end else begin
      clr_mask_s = '0;
    end
    pend_next_s    = (pend_q & ~clr_mask_s) | set_mask_s;
    pend_next_s[0] = 1'b0;
  end

  // Clear lags the FIFO write by a cycle: latch RF data is readable only after that edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q       <= '0;
      drain_q      <= 1'b0;
      drain_addr_q <= '0;
      drain_pair_q <= 1'b0;
    end else begin
      pend_q       <= pend_next_s;
      drain_q      <= fifo_wr_s;
      drain_addr_q <= head_waddr_s;
      drain_pair_q <= instr64_oe_o;
    end
  end

`ifndef SYNTHESIS
  a_pair_aligned: assert property (@(posedge clk) disable iff (!rst_n)
    !(fifo_pop_s && fifo_head_s.pair && fifo_head_s.waddr[0]))
    else $error("odd-address pair load written as base word only");

  a_apu_not_pending: assert property (@(posedge clk) disable iff (!rst_n)
    !(apu_we_i && pend_q[apu_waddr_i]))
    else $error("APU write targets a register with a pending load");
`endif

endmodule
